instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_if.sv | 29 ++
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory handshake plus the issue/retire
// handshake with the branching stage and decode.
// master = fetch unit (drives pc, imem_req/addr, instr/valid, status);
// slave  = environment (drives next_pc, exec_done, halt_req, imem_ack/rdata).
interface instr_fetch_unit_if;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        exec_done;
   logic        halt_req;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        halted;
   logic        fault;
   logic [31:0] retired;

   modport master (
      output pc, imem_req, imem_addr, instr, instr_valid, halted, fault, retired,
      input  next_pc, exec_done, halt_req, imem_ack, imem_rdata
   );

   modport slave (
      input  pc, imem_req, imem_addr, instr, instr_valid, halted, fault, retired,
      output next_pc, exec_done, halt_req, imem_ack, imem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Non-pipelined instruction fetch: FETCH -> ISSUE -> (FETCH | HALT | ERR).
// Latency: instr/instr_valid registered 1 cycle after imem_ack.
// Backpressure: instr held in ISSUE until exec_done; memory stall up to TIMEOUT cycles.
// Ports: clk/rst (sync, active-high); bus (master modport) carries pc,
// next_pc, exec_done, halt_req, imem_req/addr/ack/rdata, instr/instr_valid,
// halted, fault (sticky) and the retired-instruction counter.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned TIMEOUT       = 16,
   // Value loaded into the retired counter on reset; non-zero only to
   // exercise counter wrap without retiring 2^32 instructions.
   parameter logic [31:0] RETIRED_RESET = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst,
   instr_fetch_unit_if.master  bus
);

   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
   // Last stall cycle index; reaching it without ack means TIMEOUT cycles elapsed.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      HALT  = 2'd2,
      ERR   = 2'd3
   } state_t;

   state_t            state;
   logic [31:0]       pc_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic [31:0]       instr_q;
   logic              instr_valid_q;
   logic              halted_q;
   logic              fault_q;
   logic [31:0]       retired_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FETCH;
         pc_q          <= RESET_PC;
         wait_cnt      <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
         retired_q     <= RETIRED_RESET;
      end else begin
         case (state)
            FETCH: begin
               // Ack wins over timeout even on the final allowed cycle.
               if (bus.imem_ack) begin
                  instr_q       <= bus.imem_rdata;
                  instr_valid_q <= 1'b1;
                  state         <= ISSUE;
               end else if (wait_cnt == WAIT_LAST) begin
                  fault_q <= 1'b1;
                  state   <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ISSUE: begin
               // Counter is only meaningful in FETCH; keeping it clear here
               // guarantees every FETCH entry starts from zero.
               wait_cnt <= '0;
               if (bus.exec_done) begin
                  retired_q     <= retired_q + 32'd1;
                  instr_valid_q <= 1'b0;
                  if (bus.next_pc[1:0] != 2'b00) begin
                     fault_q <= 1'b1;
                     state   <= ERR;
                  end else begin
                     pc_q <= bus.next_pc;
                     if (bus.halt_req) begin
                        halted_q <= 1'b1;
                        state    <= HALT;
                     end else begin
                        state <= FETCH;
                     end
                  end
               end
            end
            HALT: begin
               wait_cnt <= '0;
               if (!bus.halt_req) begin
                  halted_q <= 1'b0;
                  state    <= FETCH;
               end
            end
            ERR: begin
               // Terminal until reset.
               state <= ERR;
            end
            default: state <= ERR;
         endcase
      end
   end

   assign bus.pc          = pc_q;
   assign bus.imem_req    = (state == FETCH);
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.halted      = halted_q;
   assign bus.fault       = fault_q;
   assign bus.retired     = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch/issue, stalls, timeout,
// misaligned branch, halt/resume, reset override and retired-counter wrap.
// Expected instruction words are queued when acked and popped at instr_valid.
module tb_instr_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst;
   logic rst2;

   always #5 clk = ~clk;

   instr_fetch_unit_if ifc ();
   instr_fetch_unit_if ifc2 ();

   instr_fetch_unit #(
      .RESET_PC      (RST_PC),
      .TIMEOUT       (16),
      .RETIRED_RESET (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // Second instance starts its retired count at all-ones to reach the wrap.
   instr_fetch_unit #(
      .RESET_PC      (32'h0000_0000),
      .TIMEOUT       (16),
      .RETIRED_RESET (32'hFFFF_FFFF)
   ) dut_wrap (
      .clk (clk),
      .rst (rst2),
      .bus (ifc2)
   );

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ack_word(input logic [31:0] w);
      ifc.imem_ack   = 1'b1;
      ifc.imem_rdata = w;
      exp_q.push_back(w);
      step(1);
      ifc.imem_ack   = 1'b0;
      ifc.imem_rdata = 32'h0;
   endtask

   task automatic expect_instr(input string tag);
      logic [31:0] e;
      int n = 0;
      while (ifc.instr_valid !== 1'b1 && n < 32) begin
         step(1);
         n++;
      end
      chk({tag, "_valid"}, {31'd0, ifc.instr_valid}, 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk(tag, ifc.instr, e);
   endtask

   task automatic retire(input logic [31:0] npc);
      ifc.exec_done = 1'b1;
      ifc.next_pc   = npc;
      step(1);
      ifc.exec_done = 1'b0;
      ifc.next_pc   = 32'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      rst2           = 1'b1;
      ifc.next_pc    = 32'h0;
      ifc.exec_done  = 1'b0;
      ifc.halt_req   = 1'b0;
      ifc.imem_ack   = 1'b0;
      ifc.imem_rdata = 32'h0;
      ifc2.next_pc    = 32'h4;
      ifc2.exec_done  = 1'b1;
      ifc2.halt_req   = 1'b0;
      ifc2.imem_ack   = 1'b1;
      ifc2.imem_rdata = 32'hA5A5_0000;
      step(2);

      // Reset state
      chk("rst_pc",      ifc.pc, RST_PC);
      chk("rst_instr",   ifc.instr, 32'h0);
      chk("rst_valid",   {31'd0, ifc.instr_valid}, 32'd0);
      chk("rst_halted",  {31'd0, ifc.halted}, 32'd0);
      chk("rst_fault",   {31'd0, ifc.fault}, 32'd0);
      chk("rst_retired", ifc.retired, 32'h0);
      rst = 1'b0;

      // First cycle out of reset: fetching from RESET_PC
      chk("post_rst_req",  {31'd0, ifc.imem_req}, 32'd1);
      chk("post_rst_addr", ifc.imem_addr, RST_PC);

      // Immediate ack, then retire to pc=4
      ack_word(32'hDEAD_BEEF);
      expect_instr("first_instr");
      chk("issue_req_low", {31'd0, ifc.imem_req}, 32'd0);
      retire(32'h0000_0004);
      chk("ret1_pc",      ifc.pc, 32'h4);
      chk("ret1_retired", ifc.retired, 32'd1);
      chk("ret1_req",     {31'd0, ifc.imem_req}, 32'd1);
      chk("ret1_valid",   {31'd0, ifc.instr_valid}, 32'd0);

      // Ack delayed 5 cycles: request and address held
      for (int i = 0; i < 5; i++) begin
         chk("stall_req",  {31'd0, ifc.imem_req}, 32'd1);
         chk("stall_addr", ifc.imem_addr, 32'h4);
         step(1);
      end
      ack_word(32'h1234_5678);
      expect_instr("stall_instr");
      // Hold for 10 cycles while stray acks arrive (must be ignored)
      ifc.imem_ack   = 1'b1;
      ifc.imem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 10; i++) begin
         chk("hold_instr", ifc.instr, 32'h1234_5678);
         chk("hold_valid", {31'd0, ifc.instr_valid}, 32'd1);
         step(1);
      end
      ifc.imem_ack   = 1'b0;
      ifc.imem_rdata = 32'h0;
      retire(32'h0000_0010);
      chk("ret2_pc", ifc.pc, 32'h10);

      // halt_req during FETCH does not abort the fetch
      ifc.halt_req = 1'b1;
      step(2);
      chk("halt_fetch_req", {31'd0, ifc.imem_req}, 32'd1);
      ack_word(32'hCAFE_F00D);
      expect_instr("halt_instr");
      retire(32'h0000_0008);
      chk("halt_halted", {31'd0, ifc.halted}, 32'd1);
      chk("halt_pc",     ifc.pc, 32'h8);
      chk("halt_req",    {31'd0, ifc.imem_req}, 32'd0);
      // exec_done in HALT ignored
      ifc.exec_done = 1'b1;
      ifc.next_pc   = 32'h0000_0044;
      step(3);
      ifc.exec_done = 1'b0;
      chk("halt_stay",    {31'd0, ifc.halted}, 32'd1);
      chk("halt_pc_hold", ifc.pc, 32'h8);
      chk("halt_retired", ifc.retired, 32'd3);
      ifc.halt_req = 1'b0;
      step(1);
      chk("resume_req",    {31'd0, ifc.imem_req}, 32'd1);
      chk("resume_addr",   ifc.imem_addr, 32'h8);
      chk("resume_halted", {31'd0, ifc.halted}, 32'd0);

      // Misaligned next_pc
      ack_word(32'h1111_1111);
      expect_instr("mis_instr");
      retire(32'h0000_0066);
      chk("mis_fault",   {31'd0, ifc.fault}, 32'd1);
      chk("mis_pc",      ifc.pc, 32'h8);
      chk("mis_retired", ifc.retired, 32'd4);
      chk("mis_req",     {31'd0, ifc.imem_req}, 32'd0);
      chk("mis_valid",   {31'd0, ifc.instr_valid}, 32'd0);
      ifc.imem_ack  = 1'b1;
      ifc.exec_done = 1'b1;
      step(3);
      ifc.imem_ack  = 1'b0;
      ifc.exec_done = 1'b0;
      chk("err_sticky",  {31'd0, ifc.fault}, 32'd1);
      chk("err_retired", ifc.retired, 32'd4);

      // Reset out of ERR
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("rst2_pc",      ifc.pc, RST_PC);
      chk("rst2_fault",   {31'd0, ifc.fault}, 32'd0);
      chk("rst2_retired", ifc.retired, 32'h0);

      // No ack: 16 fetch cycles then ERR
      for (int i = 0; i < 16; i++) begin
         chk("to_req", {31'd0, ifc.imem_req}, 32'd1);
         step(1);
      end
      chk("to_fault", {31'd0, ifc.fault}, 32'd1);
      chk("to_req_low", {31'd0, ifc.imem_req}, 32'd0);
      step(5);
      chk("to_sticky", {31'd0, ifc.fault}, 32'd1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("to_rst_pc",    ifc.pc, RST_PC);
      chk("to_rst_fault", {31'd0, ifc.fault}, 32'd0);

      // Ack on the 16th stalled cycle wins over the timeout
      step(15);
      chk("edge_req", {31'd0, ifc.imem_req}, 32'd1);
      ack_word(32'hBEEF_0016);
      chk("edge_fault", {31'd0, ifc.fault}, 32'd0);
      expect_instr("edge_instr");

      // Retired counter wrap on the preloaded instance
      rst2 = 1'b0;
      step(1);
      chk("wrap_pre",       ifc2.retired, 32'hFFFF_FFFF);
      chk("wrap_pre_valid", {31'd0, ifc2.instr_valid}, 32'd1);
      step(1);
      chk("wrap_retired", ifc2.retired, 32'h0);
      chk("wrap_fault",   {31'd0, ifc2.fault}, 32'd0);
      chk("wrap_pc",      ifc2.pc, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
